// File: rtl/video_console_pkg.sv
// Shared types and constants for the video_console character front end.
// Optional feature macro: VIDEO_CONSOLE_TAB_EN (horizontal-tab handling).
package video_console_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLR_ROW = 2'd1,
        CLR_ALL = 2'd2
    } state_t;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_HT = 8'h09;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam int DEF_COLS     = 100;
    localparam int DEF_ROWS     = 50;
    localparam int SCREEN_CELLS = DEF_COLS * DEF_ROWS;
    localparam int ADDR_W       = 13;

endpackage

// File: rtl/video_console_sweep.sv
// Address sweeper used for both the single-row and full-screen clears.
// Comes out of reset already sweeping RESET_COUNT cells from offset 0, so every
// reset restarts a full clear without a separate start pulse.
// Optional feature macro: none.
module video_console_sweep
    import video_console_pkg::*;
#(
    parameter int AW          = ADDR_W,
    parameter int RESET_COUNT = SCREEN_CELLS
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] count,
    output logic [AW-1:0] addr,
    output logic          active,
    output logic          done
);

    logic [AW-1:0] cur_q, cur_d;
    logic [AW-1:0] last_q, last_d;
    logic          active_q, active_d;

    // Sweep state register; reset arms a full-screen sweep.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_q    <= '0;
            last_q   <= AW'(RESET_COUNT - 1);
            active_q <= 1'b1;
        end else begin
            cur_q    <= cur_d;
            last_q   <= last_d;
            active_q <= active_d;
        end
    end

    // Load a new range on start, otherwise step one cell per cycle until the last.
    always_comb begin
        cur_d    = cur_q;
        last_d   = last_q;
        active_d = active_q;
        if (start) begin
            cur_d    = base;
            last_d   = base + count - AW'(1);
            active_d = 1'b1;
        end else if (active_q) begin
            if (cur_q == last_q) begin
                active_d = 1'b0;
            end else begin
                cur_d = cur_q + AW'(1);
            end
        end
    end

    assign addr   = cur_q;
    assign active = active_q;
    assign done   = active_q && (cur_q == last_q);

endmodule

// File: rtl/video_console.sv
// Character-stream front end for the VideoCtl screen RAM: keeps a text cursor,
// turns accepted bytes into glyph writes and runs row/screen clears.
// Optional feature macro: VIDEO_CONSOLE_TAB_EN (HT advances to next 8-column stop).
module video_console
    import video_console_pkg::*;
#(
    parameter int         COLS        = DEF_COLS,
    parameter int         ROWS        = DEF_ROWS,
    parameter int         BASE_ADDR   = 1024,
    parameter logic [7:0] BLANK_GLYPH = 8'h20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    output logic        sig_write,
    output logic [12:0] addr,
    output logic [15:0] value,
    output logic        busy,
    output logic [6:0]  cursor_x,
    output logic [5:0]  cursor_y
);

    localparam int          CELLS  = COLS * ROWS;
    localparam logic [12:0] BASE_A = 13'(BASE_ADDR);

    state_t      state_q, state_d;
    logic [6:0]  x_q, x_d;
    logic [5:0]  y_q, y_d;
    logic [12:0] row_base_q, row_base_d;
    logic        sig_write_q, sig_write_d;
    logic [12:0] addr_q, addr_d;
    logic [15:0] value_q, value_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        newline;

    logic        sweep_start;
    logic [12:0] sweep_base, sweep_count, sweep_addr;
    logic        sweep_active, sweep_done;
`ifdef VIDEO_CONSOLE_TAB_EN
    logic [7:0]  tab_x;
`endif

    video_console_sweep #(
        .AW          (13),
        .RESET_COUNT (CELLS)
    ) u_sweep (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (sweep_start),
        .base    (sweep_base),
        .count   (sweep_count),
        .addr    (sweep_addr),
        .active  (sweep_active),
        .done    (sweep_done)
    );

    // State, cursor and registered outputs; reset begins a full-screen clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CLR_ALL;
            x_q         <= '0;
            y_q         <= '0;
            row_base_q  <= '0;
            sig_write_q <= 1'b0;
            addr_q      <= '0;
            value_q     <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            row_base_q  <= row_base_d;
            sig_write_q <= sig_write_d;
            addr_q      <= addr_d;
            value_q     <= value_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    // Byte decode, cursor movement and clear sequencing.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        row_base_d  = row_base_q;
        sig_write_d = 1'b0;
        addr_d      = addr_q;
        value_d     = value_q;
        sweep_start = 1'b0;
        sweep_base  = '0;
        sweep_count = '0;
        newline     = 1'b0;
`ifdef VIDEO_CONSOLE_TAB_EN
        tab_x       = {1'b0, x_q[6:3], 3'b000} + 8'd8;
`endif
        case (state_q)
            IDLE: begin
                if (char_valid && ready_q) begin
                    if (char_data >= 8'h20) begin
                        sig_write_d = 1'b1;
                        addr_d      = BASE_A + row_base_q + {6'd0, x_q};
                        value_d     = {8'h00, char_data};
                        if (x_q == 7'(COLS - 1)) begin
                            newline = 1'b1;
                        end else begin
                            x_d = x_q + 7'd1;
                        end
                    end else begin
                        case (char_data)
                            CH_CR: x_d = '0;
                            CH_LF: newline = 1'b1;
                            CH_BS: begin
                                // Erase the cell left of the cursor; never wraps back a line.
                                if (x_q != 7'd0) begin
                                    x_d         = x_q - 7'd1;
                                    sig_write_d = 1'b1;
                                    addr_d      = BASE_A + row_base_q + {6'd0, x_q - 7'd1};
                                    value_d     = {8'h00, BLANK_GLYPH};
                                end
                            end
                            CH_FF: begin
                                x_d         = '0;
                                y_d         = '0;
                                row_base_d  = '0;
                                state_d     = CLR_ALL;
                                sweep_start = 1'b1;
                                sweep_base  = '0;
                                sweep_count = 13'(CELLS);
                            end
`ifdef VIDEO_CONSOLE_TAB_EN
                            CH_HT: begin
                                // A tab stop past the right edge acts as a line feed.
                                if (tab_x >= 8'(COLS)) begin
                                    newline = 1'b1;
                                end else begin
                                    x_d = tab_x[6:0];
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            end
            CLR_ROW, CLR_ALL: begin
                if (sweep_active) begin
                    sig_write_d = 1'b1;
                    addr_d      = BASE_A + sweep_addr;
                    value_d     = {8'h00, BLANK_GLYPH};
                end
                if (sweep_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line advance: the bottom row wraps to row 0, which is cleared first.
        if (newline) begin
            x_d = '0;
            if (y_q == 6'(ROWS - 1)) begin
                y_d         = '0;
                row_base_d  = '0;
                state_d     = CLR_ROW;
                sweep_start = 1'b1;
                sweep_base  = '0;
                sweep_count = 13'(COLS);
            end else begin
                y_d        = y_q + 6'd1;
                row_base_d = row_base_q + 13'(COLS);
            end
        end

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    assign char_ready = ready_q;
    assign sig_write  = sig_write_q;
    assign addr       = addr_q;
    assign value      = value_q;
    assign busy       = busy_q;
    assign cursor_x   = x_q;
    assign cursor_y   = y_q;

endmodule
